// File: rtl/udp_pkg.sv
// Shared types and header byte ordering for the UDP header insert stage.
package udp_pkg;
  typedef enum logic [1:0] {IDLE, HDR, DATA, BYP} state_t;

  localparam int UDP_HDR_BYTES = 8;

  // Wire order: SrcPort, DestPort, Length, Checksum, each high byte first.
  function automatic logic [7:0] hdr_byte(input logic [2:0] idx, input logic [15:0] src,
                                          input logic [15:0] dst, input logic [15:0] len,
                                          input logic [15:0] csum);
    case (idx)
      3'd0:    hdr_byte = src[15:8];
      3'd1:    hdr_byte = src[7:0];
      3'd2:    hdr_byte = dst[15:8];
      3'd3:    hdr_byte = dst[7:0];
      3'd4:    hdr_byte = len[15:8];
      3'd5:    hdr_byte = len[7:0];
      3'd6:    hdr_byte = csum[15:8];
      default: hdr_byte = csum[7:0];
    endcase
  endfunction
endpackage

// File: rtl/udp_header_insert_if.sv
// AXI-Stream bundle of configurable byte width.
interface udp_header_insert_if #(parameter int DATA_BYTES = 1);
  logic [8*DATA_BYTES-1:0] tdata;
  logic [DATA_BYTES-1:0]   tkeep;
  logic                    tlast;
  logic                    tuser;
  logic                    tvalid;
  logic                    tready;

  modport master (output tdata, tkeep, tlast, tuser, tvalid, input tready);
  modport slave  (input tdata, tkeep, tlast, tuser, tvalid, output tready);
endinterface

// File: rtl/udp_header_insert_axis_out_reg.sv
// Registered AXI-Stream output slice; loads whenever the slot is empty or draining.
module axis_out_reg #(parameter int DATA_BYTES = 1) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    in_valid,
    input  logic [8*DATA_BYTES-1:0] in_data,
    input  logic [DATA_BYTES-1:0]   in_keep,
    input  logic                    in_last,
    input  logic                    in_user,
    output logic                    load,
    udp_header_insert_if.master     m
);
    assign load = !m.tvalid || m.tready;

    always_ff @(posedge clk) begin
        if (rst) begin
            m.tvalid <= 1'b0;
            m.tdata  <= '0;
            m.tkeep  <= '0;
            m.tlast  <= 1'b0;
            m.tuser  <= 1'b0;
        end else if (load) begin
            m.tvalid <= in_valid;
            m.tdata  <= in_data;
            m.tkeep  <= in_keep;
            m.tlast  <= in_last;
            m.tuser  <= in_user;
        end
    end
endmodule

// File: rtl/udp_header_insert.sv
// Prepends the 8-byte UDP header to a payload stream, or bypasses it per packet.
// Optional UDP_LEN_CHECK_EN adds a payload length check reported on len_err.
module udp_header_insert
    import udp_pkg::*;
#(
    parameter int DATA_BYTES = 1
) (
    input  logic                s_axis_aclk,
    input  logic                s_axis_areset,
    input  logic                udp_enable,
    input  logic [15:0]         UDP_SrcPort,
    input  logic [15:0]         UDP_DestPort,
    input  logic [15:0]         UDP_TotLen,
    input  logic [15:0]         UDP_CheckSum,
`ifdef UDP_LEN_CHECK_EN
    output logic                len_err,
`endif
    udp_header_insert_if.slave  s_axis,
    udp_header_insert_if.master m_axis
);
    localparam int HDR_BEATS = UDP_HDR_BYTES / DATA_BYTES;

    state_t state_q, state_d;
    logic [3:0]  hdr_cnt, cnt_d;
    logic [15:0] src_q, dst_q, len_q, csum_q;
    logic        latch, load, s_rdy;

    logic                    in_valid, in_last, in_user;
    logic [8*DATA_BYTES-1:0] in_data, hdr_data;
    logic [DATA_BYTES-1:0]   in_keep;

    always_comb begin
        hdr_data = '0;
        for (int i = 0; i < DATA_BYTES; i++)
            hdr_data[8*i +: 8] = hdr_byte(3'(int'(hdr_cnt) * DATA_BYTES + i),
                                          src_q, dst_q, len_q, csum_q);
    end

    always_ff @(posedge s_axis_aclk) begin
        if (s_axis_areset) begin
            state_q <= IDLE;
            hdr_cnt <= '0;
            src_q   <= '0;
            dst_q   <= '0;
            len_q   <= '0;
            csum_q  <= '0;
        end else begin
            state_q <= state_d;
            hdr_cnt <= cnt_d;
            if (latch) begin
                src_q  <= UDP_SrcPort;
                dst_q  <= UDP_DestPort;
                len_q  <= UDP_TotLen;
                csum_q <= UDP_CheckSum;
            end
        end
    end

    always_comb begin
        state_d  = state_q;
        cnt_d    = hdr_cnt;
        latch    = 1'b0;
        s_rdy    = 1'b0;
        in_valid = 1'b0;
        in_data  = hdr_data;
        in_keep  = '1;
        in_last  = 1'b0;
        in_user  = 1'b0;
        case (state_q)
            IDLE: if (s_axis.tvalid) begin
                latch   = 1'b1;
                state_d = udp_enable ? HDR : BYP;
            end
            HDR: if (load) begin
                in_valid = 1'b1;
                in_user  = (hdr_cnt == 4'd0);
                if (hdr_cnt == 4'(HDR_BEATS - 1)) begin
                    cnt_d   = '0;
                    state_d = DATA;
                end else begin
                    cnt_d = hdr_cnt + 4'd1;
                end
            end
            DATA, BYP: begin
                s_rdy    = load;
                in_valid = s_axis.tvalid && load;
                in_data  = s_axis.tdata;
                in_keep  = s_axis.tkeep;
                in_last  = s_axis.tlast;
                in_user  = (state_q == BYP) && s_axis.tuser;
                if (in_valid && s_axis.tlast) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    assign s_axis.tready = s_rdy && !s_axis_areset;

    axis_out_reg #(.DATA_BYTES(DATA_BYTES)) u_out (
        .clk      (s_axis_aclk),
        .rst      (s_axis_areset),
        .in_valid (in_valid),
        .in_data  (in_data),
        .in_keep  (in_keep),
        .in_last  (in_last),
        .in_user  (in_user),
        .load     (load),
        .m        (m_axis)
    );

`ifdef UDP_LEN_CHECK_EN
    logic [15:0] byte_cnt, cnt_next;
    logic [16:0] cnt_sum;
    logic        acc;

    assign acc = in_valid && (state_q == DATA || state_q == BYP);

    always_comb begin
        cnt_sum = {1'b0, byte_cnt};
        for (int i = 0; i < DATA_BYTES; i++) cnt_sum = cnt_sum + 17'(s_axis.tkeep[i]);
        cnt_next = cnt_sum[16] ? 16'hFFFF : cnt_sum[15:0];
    end

    // The check includes the tlast beat itself, so the pulse lines up with m_axis.tlast.
    always_ff @(posedge s_axis_aclk) begin
        if (s_axis_areset || state_q == IDLE) byte_cnt <= '0;
        else if (acc)                         byte_cnt <= cnt_next;
        if (s_axis_areset) len_err <= 1'b0;
        else len_err <= acc && s_axis.tlast && (state_q == DATA) &&
                        (({1'b0, cnt_next} + 17'd8) != {1'b0, len_q});
    end
`endif
endmodule

// File: tb/tb_udp_header_insert.sv
// Directed bench for udp_header_insert at 1-byte and 4-byte stream widths.
module tb_udp_header_insert;
    logic s_axis_aclk = 1'b0;
    logic s_axis_areset = 1'b1;
    always #5 s_axis_aclk = ~s_axis_aclk;

    logic        udp_enable;
    logic [15:0] src, dst, len, csum;

    udp_header_insert_if #(.DATA_BYTES(1)) s1 ();
    udp_header_insert_if #(.DATA_BYTES(1)) m1 ();
    udp_header_insert_if #(.DATA_BYTES(4)) s4 ();
    udp_header_insert_if #(.DATA_BYTES(4)) m4 ();

`ifdef UDP_LEN_CHECK_EN
    logic len_err1, len_err4;
`endif

    udp_header_insert #(.DATA_BYTES(1)) u_dut1 (
        .s_axis_aclk(s_axis_aclk), .s_axis_areset(s_axis_areset), .udp_enable(udp_enable),
        .UDP_SrcPort(src), .UDP_DestPort(dst), .UDP_TotLen(len), .UDP_CheckSum(csum),
`ifdef UDP_LEN_CHECK_EN
        .len_err(len_err1),
`endif
        .s_axis(s1), .m_axis(m1));

    udp_header_insert #(.DATA_BYTES(4)) u_dut4 (
        .s_axis_aclk(s_axis_aclk), .s_axis_areset(s_axis_areset), .udp_enable(udp_enable),
        .UDP_SrcPort(src), .UDP_DestPort(dst), .UDP_TotLen(len), .UDP_CheckSum(csum),
`ifdef UDP_LEN_CHECK_EN
        .len_err(len_err4),
`endif
        .s_axis(s4), .m_axis(m4));

    int n_chk = 0, n_fail = 0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    typedef struct {
        logic [31:0] d;
        logic [3:0]  k;
        logic        l;
        logic        u;
        int          c;
    } beat_t;

    beat_t q1[$], q4[$];
    int    cyc = 0;
    always @(posedge s_axis_aclk) cyc <= cyc + 1;

    // m1 ready: constant high, or toggling every cycle when tog is set
    logic tog = 1'b0;
    always @(posedge s_axis_aclk) m1.tready <= tog ? !m1.tready : 1'b1;
    assign m4.tready = 1'b1;

    logic        stall1 = 1'b0;
    logic [10:0] hold1;
    int          lerr_n = 0;

    always @(negedge s_axis_aclk) begin
        if (!s_axis_areset) begin
            if (stall1) begin
                chk("stall_vld", m1.tvalid, 1'b1);
                chk("stall_hold", {m1.tdata, m1.tkeep, m1.tlast, m1.tuser}, hold1);
            end
            if (m1.tvalid && m1.tready)
                q1.push_back('{d: {24'h0, m1.tdata}, k: {3'b0, m1.tkeep}, l: m1.tlast, u: m1.tuser, c: cyc});
            if (m4.tvalid && m4.tready)
                q4.push_back('{d: m4.tdata, k: m4.tkeep, l: m4.tlast, u: m4.tuser, c: cyc});
            stall1 <= m1.tvalid && !m1.tready;
            hold1  <= {m1.tdata, m1.tkeep, m1.tlast, m1.tuser};
`ifdef UDP_LEN_CHECK_EN
            if (len_err1) begin
                lerr_n <= lerr_n + 1;
                chk("lerr_on_tlast", m1.tlast, 1'b1);
            end
`endif
        end else begin
            stall1 <= 1'b0;
        end
    end

    logic [31:0] pd[8];
    logic [3:0]  pk[8];
    logic        pu[8];
    logic [31:0] ed[16];
    logic [3:0]  ek[16];
    logic        el[16], eu[16];
    int          t_start, t_acc0;

    task automatic wait_acc(input bit wide);
        int t = 0;
        forever begin
            @(negedge s_axis_aclk);
            if (wide ? s4.tready : s1.tready) break;
            t++;
            if (t > 200) begin
                chk("accept_timeout", 1'b0, 1'b1);
                break;
            end
        end
        @(posedge s_axis_aclk);
        #1;
    endtask

    task automatic send(input bit wide, input int n);
        for (int i = 0; i < n; i++) begin
            if (wide) begin
                s4.tvalid = 1'b1; s4.tdata = pd[i]; s4.tkeep = pk[i];
                s4.tlast = (i == n - 1); s4.tuser = pu[i];
            end else begin
                s1.tvalid = 1'b1; s1.tdata = pd[i][7:0]; s1.tkeep = 1'b1;
                s1.tlast = (i == n - 1); s1.tuser = pu[i];
            end
            if (i == 0) t_start = cyc;
            wait_acc(wide);
            if (i == 0) t_acc0 = cyc - 1;
        end
        s1.tvalid = 1'b0; s4.tvalid = 1'b0;
        s1.tlast = 1'b0;  s4.tlast = 1'b0;
    endtask

    task automatic check_frame(input bit wide, input int n, input string nm);
        int t = 0;
        while ((wide ? q4.size() : q1.size()) < n && t < 400) begin
            @(negedge s_axis_aclk);
            t++;
        end
        repeat (3) @(negedge s_axis_aclk);
        chk({nm, "_beats"}, wide ? q4.size() : q1.size(), n);
        for (int i = 0; i < n && i < (wide ? q4.size() : q1.size()); i++) begin
            beat_t b;
            b = wide ? q4[i] : q1[i];
            chk($sformatf("%s_data%0d", nm, i), b.d, ed[i]);
            chk($sformatf("%s_keep%0d", nm, i), b.k, ek[i]);
            chk($sformatf("%s_last%0d", nm, i), b.l, el[i]);
            chk($sformatf("%s_user%0d", nm, i), b.u, eu[i]);
        end
    endtask

    task automatic exp_bytes(input int n, input logic [7:0] b[16]);
        for (int i = 0; i < 16; i++) begin
            ed[i] = {24'h0, b[i]}; ek[i] = 4'h1; el[i] = (i == n - 1); eu[i] = (i == 0);
        end
    endtask

    initial begin
        logic [7:0] eb[16];
        udp_enable = 1'b1; src = 16'h1234; dst = 16'h5678; len = 16'h000C; csum = 16'h0000;
        s1.tvalid = 0; s1.tdata = 0; s1.tkeep = 0; s1.tlast = 0; s1.tuser = 0;
        s4.tvalid = 0; s4.tdata = 0; s4.tkeep = 0; s4.tlast = 0; s4.tuser = 0;
        for (int i = 0; i < 8; i++) begin pd[i] = 0; pk[i] = 4'hF; pu[i] = 0; end

        repeat (4) @(posedge s_axis_aclk);
        @(negedge s_axis_aclk);
        chk("rst_tvalid", m1.tvalid, 1'b0);
        chk("rst_tdata", m1.tdata, 8'h00);
        chk("rst_tkeep", m1.tkeep, 1'b0);
        chk("rst_tlast", m1.tlast, 1'b0);
        chk("rst_tuser", m1.tuser, 1'b0);
        chk("rst_s_tready", s1.tready, 1'b0);
        chk("rst_tvalid4", m4.tvalid, 1'b0);
        @(posedge s_axis_aclk); #1;
        s_axis_areset = 1'b0;
        @(posedge s_axis_aclk); #1;

        // Insert, 1-byte lanes, ready held high
        pd[0] = 32'hAA; pd[1] = 32'hBB; pd[2] = 32'hCC; pd[3] = 32'hDD;
        eb = '{8'h12, 8'h34, 8'h56, 8'h78, 8'h00, 8'h0C, 8'h00, 8'h00,
               8'hAA, 8'hBB, 8'hCC, 8'hDD, 8'h00, 8'h00, 8'h00, 8'h00};
        exp_bytes(12, eb);
        q1.delete();
        send(1'b0, 4);
        check_frame(1'b0, 12, "ins1");
        if (q1.size() == 12) begin
            chk("hdr_latency", q1[0].c - t_start, 2);
            chk("no_gap", q1[11].c - q1[0].c, 11);
        end

        // Same packet under alternating ready; fields change after the latch
        tog = 1'b1;
        q1.delete();
        fork
            send(1'b0, 4);
            begin
                repeat (2) @(posedge s_axis_aclk);
                #2;
                src = 16'hFFFF; len = 16'h0BAD; udp_enable = 1'b0;
            end
        join
        check_frame(1'b0, 12, "stall");
        tog = 1'b0;
        src = 16'h1234; len = 16'h000C; udp_enable = 1'b1;
        repeat (2) @(posedge s_axis_aclk); #1;

        // 4-byte lanes with a partial last beat
        pd[0] = 32'h44332211; pk[0] = 4'hF;
        pd[1] = 32'h00006655; pk[1] = 4'h3;
        ed[0] = 32'h78563412; ed[1] = 32'h00000C00; ed[2] = 32'h44332211; ed[3] = 32'h00006655;
        ek[0] = 4'hF; ek[1] = 4'hF; ek[2] = 4'hF; ek[3] = 4'h3;
        el[0] = 0; el[1] = 0; el[2] = 0; el[3] = 1;
        eu[0] = 1; eu[1] = 0; eu[2] = 0; eu[3] = 0;
        q4.delete();
        send(1'b1, 2);
        check_frame(1'b1, 4, "w4");
        pk[0] = 4'hF; pk[1] = 4'hF;

        // Bypass with input tuser on the first beat
        udp_enable = 1'b0;
        pd[0] = 32'h01; pd[1] = 32'h02; pd[2] = 32'h03;
        pu[0] = 1'b1;
        eb = '{8'h01, 8'h02, 8'h03, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00,
               8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
        exp_bytes(3, eb);
        q1.delete();
        send(1'b0, 3);
        check_frame(1'b0, 3, "byp");
        if (q1.size() == 3) chk("byp_latency", q1[0].c - t_acc0, 1);
        pu[0] = 1'b0;
        udp_enable = 1'b1;
        @(posedge s_axis_aclk); #1;

        // Reset while header beat 4 sits in the output register
        len = 16'h070C;
        q1.delete();
        s1.tvalid = 1'b1; s1.tdata = 8'hAA; s1.tkeep = 1'b1; s1.tlast = 1'b0;
        for (int t = 0; t < 50 && q1.size() < 4; t++) begin
            @(posedge s_axis_aclk); #1;
        end
        chk("pre_rst_beat4", m1.tdata, 8'h07);
        s_axis_areset = 1'b1; s1.tvalid = 1'b0;
        @(posedge s_axis_aclk); #1;
        chk("midrst_tvalid", m1.tvalid, 1'b0);
        chk("midrst_tdata", m1.tdata, 8'h00);
        chk("midrst_tlast", m1.tlast, 1'b0);
        chk("midrst_s_tready", s1.tready, 1'b0);
        s_axis_areset = 1'b0;
        src = 16'hA1B2; dst = 16'hC3D4; len = 16'h0009; csum = 16'hBEEF;
        @(posedge s_axis_aclk); #1;
        q1.delete();
        pd[0] = 32'h5A;
        eb = '{8'hA1, 8'hB2, 8'hC3, 8'hD4, 8'h00, 8'h09, 8'hBE, 8'hEF,
               8'h5A, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
        exp_bytes(9, eb);
        send(1'b0, 1);
        check_frame(1'b0, 9, "postrst");

`ifdef UDP_LEN_CHECK_EN
        src = 16'h1234; dst = 16'h5678; csum = 16'h0000;
        pd[0] = 32'hAA; pd[1] = 32'hBB; pd[2] = 32'hCC; pd[3] = 32'hDD;
        len = 16'h000D;
        lerr_n = 0;
        send(1'b0, 4);
        repeat (20) @(negedge s_axis_aclk);
        chk("len_err_bad", lerr_n, 1);
        len = 16'h000C;
        lerr_n = 0;
        @(posedge s_axis_aclk); #1;
        send(1'b0, 4);
        repeat (20) @(negedge s_axis_aclk);
        chk("len_err_good", lerr_n, 0);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule

// File: doc/udp_header_insert.md
Name: udp_header_insert

Overview:
- Parametrised successor to the byte-wide UDP header stage.
- Prepends the 8-byte UDP header (SrcPort, DestPort, Length, Checksum; big-endian) to an AXI-Stream payload of configurable byte width.
- Supports full m_axis_tready backpressure through a registered output stage.
- Sits between the application payload source and the IPv4 header stage; udp_enable selects insert or bypass per packet.

Parameters:
- DATA_BYTES, 1: stream width in bytes; legal values 1, 2, 4, 8 (must divide 8).
- HDR_BEATS, 8/DATA_BYTES: derived localparam, header length in beats; not overridable.

Ports:
- s_axis_aclk  in  1  clock, all logic rising-edge.
- s_axis_areset  in  1  synchronous active-high reset.
- udp_enable  in  1  1 = insert header, 0 = bypass; sampled at packet start only.
- UDP_SrcPort  in  16  source port.
- UDP_DestPort  in  16  destination port.
- UDP_TotLen  in  16  UDP length field, header plus payload, in bytes.
- UDP_CheckSum  in  16  checksum field, inserted verbatim.
- s_axis_tdata  in  8*DATA_BYTES  payload; lane 0 = bits [7:0] = first byte on the wire.
- s_axis_tkeep  in  DATA_BYTES  byte valid; only the tlast beat may be partial.
- s_axis_tlast  in  1  end of payload.
- s_axis_tuser  in  1  start-of-frame; forwarded in bypass only.
- s_axis_tvalid  in  1  payload valid.
- s_axis_tready  out  1  payload accepted.
- m_axis_tdata  out  8*DATA_BYTES  framed output.
- m_axis_tkeep  out  DATA_BYTES  output byte valid.
- m_axis_tlast  out  1  end of frame.
- m_axis_tuser  out  1  start-of-frame, on the first output beat.
- m_axis_tvalid  out  1  output valid.
- m_axis_tready  in  1  downstream ready.

Behaviour:
- Reset values: state = IDLE, beat counter = 0, m_axis_tvalid = 0, tlast = 0, tuser = 0, tkeep = 0, tdata = 0. s_axis_tready = 0 while reset is asserted.
- Output register:
  - m_* loads when (!m_axis_tvalid || m_axis_tready).
  - m_* holds stable while tvalid=1 and tready=0.
- States:
  - IDLE:
    - s_axis_tready = 0.
    - On s_axis_tvalid=1, latch udp_enable and all four header fields into shadow registers.
    - Go to HDR if latched enable = 1, else to BYP.
    - No input beat is consumed in IDLE.
  - HDR:
    - s_axis_tready = 0.
    - Each output load emits header beat k (0..HDR_BEATS-1).
    - Byte i of beat k is header byte k*DATA_BYTES+i, in order SrcPort[15:8], SrcPort[7:0], DestPort, TotLen, CheckSum (high byte first).
    - tkeep is all ones; tuser = 1 on k=0 only; tlast = 0.
    - After beat HDR_BEATS-1 is loaded, go to DATA.
  - DATA:
    - s_axis_tready = (!m_axis_tvalid || m_axis_tready).
    - Each accepted beat is copied to m_* with tuser = 0; tdata, tkeep and tlast are passed through.
    - The accepted beat with tlast=1 returns the FSM to IDLE.
  - BYP:
    - Same as DATA, except s_axis_tuser is forwarded unchanged.
    - Returns to IDLE on the accepted tlast beat.
- Latency:
  - Header: the first header beat is valid 2 cycles after s_axis_tvalid rises in IDLE (IDLE-to-HDR cycle, then the register load).
  - Payload: 1 cycle, input accept to m_axis_tvalid.
- Throughput: one beat per cycle with tready held high. In insert mode the frame is HDR_BEATS beats longer than the payload; there are no gaps between header and payload.
- Field sampling: changes to the header fields or udp_enable after the IDLE latch have no effect until the next packet.
- Back-to-back packets: one idle input cycle (the IDLE state) between packets is allowed and required.
- Single-beat payload with tlast=1: legal; the frame is HDR_BEATS+1 beats.
- Zero-length payload: not supported; the source must send at least one beat.
- Reset mid-frame: the frame is abandoned, the output is cleared on the same edge, and no tlast is emitted. Downstream must tolerate the truncated frame.
- Length checking: TotLen is not checked against the payload length unless the optional feature is compiled in.

Optional Feature:
- Macro: UDP_LEN_CHECK_EN.
- Defined:
  - Adds output len_err (1 bit, reset 0).
  - A 16-bit counter sums popcount(tkeep) over accepted payload beats; it clears in IDLE and saturates at 16'hFFFF.
  - On the accepted tlast beat in HDR-mode packets, len_err pulses for 1 cycle if (count + 8) != latched TotLen.
  - The frame is still forwarded unmodified.
- Undefined: no counter, no len_err port.

Decomposition:
- Package udp_pkg:
  - state enum (IDLE, HDR, DATA, BYP);
  - UDP_HDR_BYTES = 8;
  - function hdr_byte(idx, src, dst, len, csum) returning header byte idx.
- Sub-module: axis_out_reg, the output register slice, parametrised by DATA_BYTES; it owns the load-enable rule.

Test Plan:
- DATA_BYTES=1, enable=1, SrcPort=16'h1234, DestPort=16'h5678, TotLen=16'h000C, CheckSum=0, payload AA BB CC DD (tlast on DD), tready=1 -> output 12 34 56 78 00 0C 00 00 AA BB CC DD; tuser on 12 only; tlast on DD.
- Same stimulus, tready toggling 1010... -> identical byte sequence; no beat lost or duplicated; m_* stable during stalls.
- DATA_BYTES=4, payload of 2 beats with tkeep 4'hF then 4'h3 -> header beats 32'h78563412 and 32'h00000C00 with checksum 0, then the payload; last tkeep = 4'h3.
- enable=0, 3-beat packet with s_axis_tuser=1 on beat 0 -> output equals input, 1-cycle latency, no header.
- Reset asserted on header beat 4, then a new packet -> outputs clear the next edge; the new frame starts cleanly with the header byte 0 it latched.
- UDP_LEN_CHECK_EN, TotLen=16'h000D with a 4-byte payload -> len_err pulses once with the tlast beat; with TotLen=16'h000C, len_err stays 0.
